// File: rtl/apogeo_pkg.sv
// Shared core types plus the writeback-arbiter entry format and channel count.
// ITU/LSU/CSR index the per-channel result buses throughout the core.
package apogeo_pkg;

    typedef logic [31:0] data_word_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [3:0]  rob_tag;
    } instr_packet_t;

    localparam logic [1:0] ITU = 2'd0;
    localparam logic [1:0] LSU = 2'd1;
    localparam logic [1:0] CSR = 2'd2;

    localparam int WB_CHANNELS = 3;

    typedef struct packed {
        data_word_t    result;
        instr_packet_t ipacket;
    } wb_entry_t;

    // Channel following ch in round-robin order, wrapping CSR back to ITU.
    function automatic logic [1:0] wb_next_ch(input logic [1:0] ch);
        return (ch == CSR) ? ITU : ch + 2'd1;
    endfunction

endpackage

// File: rtl/exu_writeback_arbiter_if.sv
// Result-channel and writeback-port bundle for exu_writeback_arbiter.
// master = the arbiter, slave = producers plus the commit stage.
interface exu_writeback_arbiter_if;
    import apogeo_pkg::*;

    logic                                flush_i;
    data_word_t    [WB_CHANNELS-1:0]     result_i;
    instr_packet_t [WB_CHANNELS-1:0]     ipacket_i;
    logic          [WB_CHANNELS-1:0]     data_valid_i;
    logic                                wb_ready_i;
    logic                                wb_valid_o;
    data_word_t                          wb_result_o;
    instr_packet_t                       wb_ipacket_o;
    logic          [1:0]                 wb_channel_o;
    logic                                stall_o;
    logic                                overflow_o;
    logic                                empty_o;

    modport master (
        input  flush_i, result_i, ipacket_i, data_valid_i, wb_ready_i,
        output wb_valid_o, wb_result_o, wb_ipacket_o, wb_channel_o,
               stall_o, overflow_o, empty_o
    );

    modport slave (
        output flush_i, result_i, ipacket_i, data_valid_i, wb_ready_i,
        input  wb_valid_o, wb_result_o, wb_ipacket_o, wb_channel_o,
               stall_o, overflow_o, empty_o
    );

endinterface

// File: rtl/exu_writeback_arbiter_wb_result_fifo.sv
// wb_result_fifo: first-word-fall-through result buffer with synchronous flush.
// A push into a full FIFO lands only when the same cycle also pops.
module wb_result_fifo
    import apogeo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  wb_entry_t     data_i,
    input  logic          pop_i,
    output wb_entry_t     data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    // Storage needs no reset: a slot is only observed once count covers it.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/exu_writeback_arbiter.sv
// Serialises ITU/LSU/CSR results onto the single writeback port to the ROB.
// Build option APOGEO_WB_ROUND_ROBIN_EN selects round-robin; default is LSU > CSR > ITU.
module exu_writeback_arbiter
    import apogeo_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    exu_writeback_arbiter_if.master wb
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t [WB_CHANNELS-1:0]         push_data;
    wb_entry_t [WB_CHANNELS-1:0]         head;
    logic      [WB_CHANNELS-1:0][CW-1:0] count;
    logic      [WB_CHANNELS-1:0]         fifo_empty;
    logic      [WB_CHANNELS-1:0]         fifo_full;
    logic      [WB_CHANNELS-1:0]         near_full;
    logic      [WB_CHANNELS-1:0]         pop;

    logic       any_valid;
    logic       fire;
    logic [1:0] arb_grant;
    logic [1:0] grant;
    logic       locked;
    logic [1:0] lock_ch;
    logic       overflow_q;
    logic       overflow_set;

    assign any_valid = ~&fifo_empty;
    assign fire      = any_valid & wb.wb_ready_i;

    for (genvar k = 0; k < WB_CHANNELS; k++) begin : g_fifo
        assign push_data[k] = '{result: wb.result_i[k], ipacket: wb.ipacket_i[k]};
        assign pop[k]       = fire & (grant == 2'(k));
        assign near_full[k] = (count[k] >= CW'(FIFO_DEPTH - 1));

        wb_result_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .flush_i (wb.flush_i),
            .push_i  (wb.data_valid_i[k]),
            .data_i  (push_data[k]),
            .pop_i   (pop[k]),
            .data_o  (head[k]),
            .count_o (count[k]),
            .full_o  (fifo_full[k]),
            .empty_o (fifo_empty[k])
        );
    end

`ifdef APOGEO_WB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;
    logic       found;

    // Search starts at rr_ptr; the first non-empty channel in order wins.
    always_comb begin
        arb_grant = rr_ptr;
        cand      = rr_ptr;
        found     = 1'b0;
        for (int i = 0; i < WB_CHANNELS; i++) begin
            if (!found && !fifo_empty[cand]) begin
                arb_grant = cand;
                found     = 1'b1;
            end
            cand = wb_next_ch(cand);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)        rr_ptr <= ITU;
        else if (wb.flush_i) rr_ptr <= ITU;
        else if (fire)       rr_ptr <= wb_next_ch(grant);
    end
`else
    always_comb begin
        arb_grant = ITU;
        if (!fifo_empty[LSU])      arb_grant = LSU;
        else if (!fifo_empty[CSR]) arb_grant = CSR;
    end
`endif

    // While the commit stage stalls us, freeze the presented channel so a
    // newly arriving higher-priority result cannot swap the offered entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            locked  <= 1'b0;
            lock_ch <= ITU;
        end else if (wb.flush_i) begin
            locked  <= 1'b0;
        end else if (any_valid && !wb.wb_ready_i) begin
            locked  <= 1'b1;
            lock_ch <= grant;
        end else begin
            locked  <= 1'b0;
        end
    end

    assign grant = locked ? lock_ch : arb_grant;

    assign overflow_set = |(wb.data_valid_i & fifo_full & ~pop) & ~wb.flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)          overflow_q <= 1'b0;
        else if (overflow_set) overflow_q <= 1'b1;
    end

    always_comb begin
        wb.wb_valid_o   = any_valid;
        wb.wb_result_o  = '0;
        wb.wb_ipacket_o = '0;
        wb.wb_channel_o = 2'd0;
        if (any_valid) begin
            wb.wb_result_o  = head[grant].result;
            wb.wb_ipacket_o = head[grant].ipacket;
            wb.wb_channel_o = grant;
        end
        wb.stall_o    = |near_full;
        wb.overflow_o = overflow_q;
        wb.empty_o    = ~any_valid;
    end

endmodule

// File: tb/tb_exu_writeback_arbiter.sv
// Directed bench for exu_writeback_arbiter (FIFO_DEPTH = 4), both arbitration builds.
module tb_exu_writeback_arbiter;
    import apogeo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [1:0] ord [3];

    exu_writeback_arbiter_if wb_bus ();

    exu_writeback_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .wb      (wb_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_push();
        wb_bus.data_valid_i = '0;
        wb_bus.result_i     = '0;
        wb_bus.ipacket_i    = '0;
    endtask

    task automatic push(input int ch, input logic [31:0] val);
        wb_bus.data_valid_i[ch] = 1'b1;
        wb_bus.result_i[ch]     = val;
        wb_bus.ipacket_i[ch]    = '{pc: 32'h100 + val, rd_addr: 5'(ch), rob_tag: 4'(val)};
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"},    64'(wb_bus.wb_valid_o),   64'(0));
        check({tag, "_result"},   64'(wb_bus.wb_result_o),  64'(0));
        check({tag, "_ipacket"},  64'(wb_bus.wb_ipacket_o), 64'(0));
        check({tag, "_channel"},  64'(wb_bus.wb_channel_o), 64'(0));
        check({tag, "_empty"},    64'(wb_bus.empty_o),      64'(1));
        check({tag, "_stall"},    64'(wb_bus.stall_o),      64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wb_bus.flush_i    = 1'b0;
        wb_bus.wb_ready_i = 1'b0;
        clear_push();
        #2;
        check_idle("rst");
        check("rst_overflow", 64'(wb_bus.overflow_o), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_rst");

        // Simultaneous push on all three channels, ready high.
`ifdef APOGEO_WB_ROUND_ROBIN_EN
        ord[0] = ITU; ord[1] = LSU; ord[2] = CSR;
`else
        ord[0] = LSU; ord[1] = CSR; ord[2] = ITU;
`endif
        wb_bus.wb_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) push(k, 32'(k + 1));
        tick();
        clear_push();
        check("sim_pc0", 64'(wb_bus.wb_ipacket_o.pc), 64'(32'h100 + 32'(ord[0]) + 1));
        for (int i = 0; i < 3; i++) begin
            check("sim_channel", 64'(wb_bus.wb_channel_o), 64'(ord[i]));
            check("sim_result",  64'(wb_bus.wb_result_o),  64'(ord[i]) + 64'(1));
            tick();
        end
        check("sim_empty", 64'(wb_bus.empty_o), 64'(1));

        // Single ITU push, one-cycle latency, drained next cycle.
        push(0, 32'hAA);
        tick();
        clear_push();
        check("single_valid",   64'(wb_bus.wb_valid_o),   64'(1));
        check("single_result",  64'(wb_bus.wb_result_o),  64'hAA);
        check("single_channel", 64'(wb_bus.wb_channel_o), 64'(ITU));
        check("single_empty0",  64'(wb_bus.empty_o),      64'(0));
        tick();
        check_idle("single_drained");

        // Backpressure with two LSU entries.
        wb_bus.wb_ready_i = 1'b0;
        push(1, 32'h10);
        tick();
        push(1, 32'h11);
        tick();
        clear_push();
        for (int i = 0; i < 5; i++) begin
            check("bp_result",  64'(wb_bus.wb_result_o),  64'h10);
            check("bp_channel", 64'(wb_bus.wb_channel_o), 64'(LSU));
            tick();
        end
        wb_bus.wb_ready_i = 1'b1;
        check("bp_pop0", 64'(wb_bus.wb_result_o), 64'h10);
        tick();
        check("bp_pop1", 64'(wb_bus.wb_result_o), 64'h11);
        tick();
        check("bp_empty", 64'(wb_bus.empty_o), 64'(1));

        // Grant held on ITU while a preferred CSR result arrives during stall.
        wb_bus.wb_ready_i = 1'b0;
        push(0, 32'h20);
        tick();
        clear_push();
        push(2, 32'h21);
        tick();
        clear_push();
        for (int i = 0; i < 3; i++) begin
            check("lock_channel", 64'(wb_bus.wb_channel_o), 64'(ITU));
            check("lock_result",  64'(wb_bus.wb_result_o),  64'h20);
            tick();
        end
        wb_bus.wb_ready_i = 1'b1;
        tick();
        check("lock_next_channel", 64'(wb_bus.wb_channel_o), 64'(CSR));
        check("lock_next_result",  64'(wb_bus.wb_result_o),  64'h21);
        tick();
        check("lock_empty", 64'(wb_bus.empty_o), 64'(1));

        // Near-full, full-with-room-for-in-flight, then overflow drop.
        wb_bus.wb_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(1, 32'h30 + 32'(i));
            tick();
            clear_push();
            check("nf_stall",    64'(wb_bus.stall_o),    64'(i >= 2));
            check("nf_overflow", 64'(wb_bus.overflow_o), 64'(i >= 4));
        end
        wb_bus.wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("nf_drain", 64'(wb_bus.wb_result_o), 64'h30 + 64'(i));
            tick();
        end
        check("nf_empty",      64'(wb_bus.empty_o),    64'(1));
        check("nf_stall_off",  64'(wb_bus.stall_o),    64'(0));
        check("nf_sticky",     64'(wb_bus.overflow_o), 64'(1));

        // Flush with two entries per channel plus a same-cycle ITU push.
        wb_bus.wb_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) push(k, 32'h40 + 32'(k));
        tick();
        for (int k = 0; k < 3; k++) push(k, 32'h50 + 32'(k));
        tick();
        clear_push();
        check("fl_pre_stall", 64'(wb_bus.stall_o),   64'(0));
        check("fl_pre_valid", 64'(wb_bus.wb_valid_o), 64'(1));
        wb_bus.flush_i    = 1'b1;
        wb_bus.wb_ready_i = 1'b1;
        push(0, 32'h99);
        tick();
        wb_bus.flush_i = 1'b0;
        clear_push();
        check_idle("fl");
        check("fl_overflow", 64'(wb_bus.overflow_o), 64'(1));
        repeat (2) begin
            tick();
            check("fl_no_ghost", 64'(wb_bus.wb_valid_o), 64'(0));
        end
`ifdef APOGEO_WB_ROUND_ROBIN_EN
        ord[0] = ITU; ord[1] = CSR;
`else
        ord[0] = CSR; ord[1] = ITU;
`endif
        push(0, 32'h61);
        push(2, 32'h62);
        tick();
        clear_push();
        check("fl_order0", 64'(wb_bus.wb_channel_o), 64'(ord[0]));
        tick();
        check("fl_order1", 64'(wb_bus.wb_channel_o), 64'(ord[1]));
        tick();
        check("fl_order_empty", 64'(wb_bus.empty_o), 64'(1));

        // Asynchronous reset mid-stream.
        wb_bus.wb_ready_i = 1'b0;
        push(0, 32'h70);
        push(1, 32'h71);
        tick();
        clear_push();
        check("ar_pre_valid", 64'(wb_bus.wb_valid_o), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("ar");
        check("ar_overflow", 64'(wb_bus.overflow_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wb_bus.wb_ready_i = 1'b1;
        push(0, 32'h80);
        tick();
        clear_push();
        check("ar_new_result",  64'(wb_bus.wb_result_o),  64'h80);
        check("ar_new_channel", 64'(wb_bus.wb_channel_o), 64'(ITU));
        tick();
        check("ar_new_empty", 64'(wb_bus.empty_o), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
